// File: rtl/sid_bus_if.sv
// SID host bus: phi2 timing, chip select, address/data, and register-file strobes.
interface sid_bus_if;
  logic       phi2;
  logic       bus_res;
  logic       cs_n;
  logic       r_w_n;
  logic [4:0] addr;
  logic [7:0] data_i;
  logic [7:0] rd_data_i;
  logic       wr_en;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;
  logic       rd_en;
  logic [4:0] rd_addr;
  logic [7:0] data_o;
  logic [7:0] bus_value;

  modport slave (
    input  phi2, bus_res, cs_n, r_w_n, addr, data_i, rd_data_i,
    output wr_en, wr_addr, wr_data, rd_en, rd_addr, data_o, bus_value
  );

  modport master (
    output phi2, bus_res, cs_n, r_w_n, addr, data_i, rd_data_i,
    input  wr_en, wr_addr, wr_data, rd_en, rd_addr, data_o, bus_value
  );
endinterface

// File: rtl/sid_bus_ctrl.sv
// SID bus controller: turns phi2-timed host cycles into single-cycle register
// strobes and models the decaying SID-internal data bus.
module sid_bus_ctrl #(
  parameter logic [23:0] DECAY_CYCLES = 24'd8000
) (
  input  logic     clk,
  input  logic     rst_n,
  sid_bus_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RD_REQ    = 3'd1,
    RD_CAP    = 3'd2,
    WAIT_FALL = 3'd3,
    WR        = 3'd4
  } state_t;

  state_t      state;
  logic        phi2_d;
  logic        armed;      // masks the first cycle so reset release never looks like an edge
  logic        fall_seen;  // phi2 fell before the read capture finished
  logic [23:0] cnt;
  logic        rise, fall, wr_start, reg_rd;

  assign rise     = armed &  bus.phi2 & ~phi2_d;
  assign fall     = armed & ~bus.phi2 &  phi2_d;
  assign wr_start = fall & ~bus.cs_n & ~bus.r_w_n & (state == IDLE);
  assign reg_rd   = (bus.rd_addr >= 5'h19) && (bus.rd_addr <= 5'h1C);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      phi2_d        <= 1'b0;
      armed         <= 1'b0;
      fall_seen     <= 1'b0;
      cnt           <= 24'd0;
      bus.wr_en     <= 1'b0;
      bus.rd_en     <= 1'b0;
      bus.wr_addr   <= 5'd0;
      bus.rd_addr   <= 5'd0;
      bus.wr_data   <= 8'h00;
      bus.data_o    <= 8'h00;
      bus.bus_value <= 8'h00;
    end else begin
      phi2_d <= bus.phi2;
      armed  <= 1'b1;
      if (bus.bus_res) begin
        state         <= IDLE;
        fall_seen     <= 1'b0;
        cnt           <= 24'd0;
        bus.wr_en     <= 1'b0;
        bus.rd_en     <= 1'b0;
        bus.data_o    <= 8'h00;
        bus.bus_value <= 8'h00;
      end else begin
        bus.wr_en <= 1'b0;
        bus.rd_en <= 1'b0;
        // Decay runs on every fall; later assignments below (write/read) override it.
        if (fall && !wr_start && cnt != DECAY_CYCLES) begin
          cnt <= cnt + 24'd1;
          if (cnt == DECAY_CYCLES - 24'd1) bus.bus_value <= 8'h00;
        end
        case (state)
          IDLE: begin
            if (rise && !bus.cs_n && bus.r_w_n) begin
              bus.rd_en   <= 1'b1;
              bus.rd_addr <= bus.addr;
              fall_seen   <= 1'b0;
              state       <= RD_REQ;
            end else if (wr_start) begin
              bus.wr_en     <= 1'b1;
              bus.wr_addr   <= bus.addr;
              bus.wr_data   <= bus.data_i;
              bus.bus_value <= bus.data_i;
              cnt           <= 24'd0;
              state         <= WR;
            end
          end
          RD_REQ: begin
            if (fall) fall_seen <= 1'b1;
            state <= RD_CAP;
          end
          RD_CAP: begin
            if (reg_rd) begin
              bus.data_o    <= bus.rd_data_i;
              bus.bus_value <= bus.rd_data_i;
              cnt           <= 24'd0;
            end else begin
              bus.data_o <= bus.bus_value;
            end
            state <= (fall || fall_seen) ? IDLE : WAIT_FALL;
          end
          WAIT_FALL: if (fall) state <= IDLE;
          WR:        state <= IDLE;
          default:   state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: doc/sid_bus_ctrl.md
SID_BUS_CTRL -- requirements
Module: sid_bus_ctrl

Interface
REQ-001 Parameter DECAY_CYCLES, default 24'd8000, phi2 cycles after which an undriven bus_value decays to 8'h00.
REQ-002 clk  input  1  FPGA system clock; all logic on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 phi2  input  1  phi2 already synchronized to clk.
REQ-005 bus_res  input  1  synchronous SID bus reset, active-high.
REQ-006 cs_n, r_w_n  input  1 each  chip select and read/write, latched during phi1.
REQ-007 addr  input  5  register address.
REQ-008 data_i  input  8  data bus input.
REQ-009 rd_data_i  input  8  register-file read data for addresses 0x19-0x1C, valid the cycle after rd_en.
REQ-010 wr_en  output  1  one-cycle register write strobe.
REQ-011 wr_addr, wr_data  output  5, 8  write address and data, valid while wr_en=1.
REQ-012 rd_en  output  1  one-cycle register read strobe.
REQ-013 rd_addr  output  5  read address, valid while rd_en=1.
REQ-014 data_o  output  8  read data to the data pad output register.
REQ-015 bus_value  output  8  last value on the SID-internal data bus.

Function
REQ-016 Edge detect: register phi2 as phi2_d; rise = phi2 & ~phi2_d; fall = ~phi2 & phi2_d; rise and fall are mutually exclusive.
REQ-017 FSM states: IDLE, RD_REQ, RD_CAP, WAIT_FALL, WR.
REQ-018 IDLE -> RD_REQ on rise with cs_n=0, r_w_n=1, bus_res=0.
REQ-019 RD_REQ: rd_en=1, rd_addr=addr for exactly one cycle, then -> RD_CAP.
REQ-020 RD_CAP: data_o <= rd_data_i when addr is 0x19-0x1C, else data_o <= bus_value; then -> WAIT_FALL.
REQ-021 A read of 0x19-0x1C also loads bus_value with rd_data_i and clears the decay counter.
REQ-022 Reads of all other addresses leave bus_value and the decay counter unchanged.
REQ-023 WAIT_FALL -> IDLE on fall; data_o holds its value until the next RD_CAP.
REQ-024 IDLE -> WR on fall with cs_n=0, r_w_n=0, bus_res=0.
REQ-025 WR: wr_en=1, wr_addr=addr, wr_data=data_i for exactly one cycle, using values sampled on the fall cycle.
REQ-026 WR: bus_value <= data_i and decay counter <= 0; then -> IDLE.
REQ-027 wr_en and rd_en are never both 1; each fires at most once per phi2 period.
REQ-028 Decay counter: 24-bit; increments on every fall not coincident with a write.
REQ-029 Decay counter saturates at DECAY_CYCLES; on reaching DECAY_CYCLES, bus_value <= 8'h00.
REQ-030 cs_n=1 on a rise or fall produces no strobe and no state change other than decay.
REQ-031 bus_res=1 in any state: next state IDLE; wr_en=rd_en=0; bus_value, data_o and counter cleared to 0.
REQ-032 A phi2 fall while in RD_REQ or RD_CAP (phi2 high time shorter than 3 clk) still completes RD_CAP, then returns to IDLE.
REQ-033 wr_en and rd_en are registered outputs; no combinational path from inputs to outputs.

Reset
REQ-034 On rst_n=0, asynchronously set state=IDLE, phi2_d=0, wr_en=rd_en=0, wr_addr=rd_addr=0, wr_data=data_o=bus_value=0, counter=0.
REQ-035 Release of rst_n with phi2=1 does not generate a rise event.

Verification
REQ-036 Write 8'hA5 to addr 0x18 -> single wr_en pulse one clk after fall; wr_addr=0x18, wr_data=8'hA5; bus_value=8'hA5.
REQ-037 Read addr 0x1B with rd_data_i=8'h3C -> rd_en one clk after rise, rd_addr=0x1B; data_o=8'h3C and bus_value=8'h3C two clk after rise.
REQ-038 Write 8'h5A to 0x04, then read 0x04 -> data_o=8'h5A and no change to the decay counter.
REQ-039 Write 8'hFF, then DECAY_CYCLES-1 idle phi2 periods -> bus_value=8'hFF; after one more fall -> bus_value=8'h00.
REQ-040 Assert bus_res during RD_CAP -> next clk state IDLE, data_o=0, bus_value=0, no strobes while bus_res=1.
REQ-041 cs_n=1 for 10 phi2 periods with alternating r_w_n -> no wr_en or rd_en; decay counter advances by 10.
